// File: rtl/hdc_sensor_fusion.sv
// HDC emotion classifier: Rule-90 channel IDs bound with level hypervectors, majority bundling, then Hamming search.
// Optional macro HDC_MAJ_TIE_ONE_EN: bundle ties (2*count == N) resolve to 1 instead of 0.
`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 4
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 2
`endif

module hdc_am #(
   parameter int                HV_DIM = 2000,
   parameter logic [HV_DIM-1:0] V_HI   = '0,
   parameter logic [HV_DIM-1:0] V_LO   = '0,
   parameter logic [HV_DIM-1:0] A_HI   = '0,
   parameter logic [HV_DIM-1:0] A_LO   = '0
) (
   input  logic [HV_DIM-1:0] query_i,
   output logic              valence_o,
   output logic              arousal_o
);
   localparam int HW = $clog2(HV_DIM + 1);

   function automatic logic [HW-1:0] popcount(input logic [HV_DIM-1:0] v);
      logic [HW-1:0] sum;
      sum = '0;
      for (int j = 0; j < HV_DIM; j++) begin
         sum = sum + HW'(v[j]);
      end
      return sum;
   endfunction

   // Equal distances fall to the low class.
   always_comb begin
      valence_o = (popcount(query_i ^ V_HI) < popcount(query_i ^ V_LO)) ? 1'b1 : 1'b0;
      arousal_o = (popcount(query_i ^ A_HI) < popcount(query_i ^ A_LO)) ? 1'b1 : 1'b0;
   end
endmodule

module hdc_sensor_fusion #(
   parameter int                TOTAL_NUM_CHANNEL = `TOTAL_NUM_CHANNEL,
   parameter int                CHANNEL_WIDTH     = `CHANNEL_WIDTH,
   parameter int                HV_DIM            = 2000,
   parameter logic [HV_DIM-1:0] ID_SEED           = HV_DIM'({128{32'h9E37_79B9}}),
   parameter logic [HV_DIM-1:0] LEVEL_SEED        = HV_DIM'({128{32'h5A3C_96E1}}),
   parameter logic [HV_DIM-1:0] V_HI              = HV_DIM'({128{32'hF0F0_1234}}),
   parameter logic [HV_DIM-1:0] V_LO              = HV_DIM'({128{32'h0F0F_EDCB}}),
   parameter logic [HV_DIM-1:0] A_HI              = HV_DIM'({128{32'h3C3C_A5A5}}),
   parameter logic [HV_DIM-1:0] A_LO              = HV_DIM'({128{32'hC3C3_5A5A}})
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [TOTAL_NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top,
   input  logic                                       fin_valid,
   output logic                                       fin_ready,
   output logic                                       valence,
   output logic                                       arousal,
   output logic                                       dout_valid,
   input  logic                                       dout_ready
);
   localparam int N    = TOTAL_NUM_CHANNEL;
   localparam int W    = CHANNEL_WIDTH;
   localparam int D    = HV_DIM;
   localparam int CW   = $clog2(N + 1);
   localparam int CHW  = $clog2(N + 1);
   localparam int STEP = D >> W;
   localparam logic [CHW-1:0] CH_LAST = CHW'(N - 1);
   localparam logic [CW:0]    N_CMP   = (CW + 1)'(N);

   typedef enum logic [2:0] {S_IDLE, S_ENCODE, S_BUNDLE, S_SEARCH, S_DONE} state_t;

   state_t           state_q;
   logic [N*W-1:0]   feat_q;
   logic [D-1:0]     id_hv_q;
   logic [CHW-1:0]   ch_q;
   logic [CW-1:0]    cnt_q [D];
   logic [D-1:0]     query_q;
   logic [D-1:0]     query_d;
   logic             fin_ready_q;
   logic             dout_valid_q;
   logic             valence_q;
   logic             arousal_q;
   logic [W-1:0]     q_ch_s;
   logic [D-1:0]     bound_s;
   logic             am_valence_s;
   logic             am_arousal_s;

   function automatic logic [D-1:0] rule90(input logic [D-1:0] cur);
      logic [D-1:0] nxt;
      for (int j = 0; j < D; j++) begin
         nxt[j] = cur[(j + D - 1) % D] ^ cur[(j + 1) % D];
      end
      return nxt;
   endfunction

   function automatic logic [D-1:0] level_mask(input logic [W-1:0] q);
      logic [D-1:0] m;
      for (int j = 0; j < D; j++) begin
         m[j] = (j < int'(q) * STEP) ? 1'b1 : 1'b0;
      end
      return m;
   endfunction

   // Select the current channel's feature and bind it with the running channel ID.
   always_comb begin
      q_ch_s = '0;
      for (int c = 0; c < N; c++) begin
         if (ch_q == CHW'(c)) begin
            q_ch_s = feat_q[c*W +: W];
         end else begin
            q_ch_s = q_ch_s;
         end
      end
      bound_s = id_hv_q ^ LEVEL_SEED ^ level_mask(q_ch_s);
   end

   // Majority threshold on the per-dimension counters.
   always_comb begin
      query_d = '0;
      for (int j = 0; j < D; j++) begin
`ifdef HDC_MAJ_TIE_ONE_EN
         query_d[j] = ({cnt_q[j], 1'b0} >= N_CMP) ? 1'b1 : 1'b0;
`else
         query_d[j] = ({cnt_q[j], 1'b0} > N_CMP) ? 1'b1 : 1'b0;
`endif
      end
   end

   hdc_am #(
      .HV_DIM (D),
      .V_HI   (V_HI),
      .V_LO   (V_LO),
      .A_HI   (A_HI),
      .A_LO   (A_LO)
   ) u_am (
      .query_i   (query_q),
      .valence_o (am_valence_s),
      .arousal_o (am_arousal_s)
   );

   // Control FSM with datapath registers; DONE drains one cycle after the handshake before IDLE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         feat_q       <= '0;
         id_hv_q      <= '0;
         ch_q         <= '0;
         query_q      <= '0;
         fin_ready_q  <= 1'b1;
         dout_valid_q <= 1'b0;
         valence_q    <= 1'b0;
         arousal_q    <= 1'b0;
         for (int j = 0; j < D; j++) cnt_q[j] <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (fin_valid && fin_ready_q) begin
                  feat_q      <= features_top;
                  id_hv_q     <= ID_SEED;
                  ch_q        <= '0;
                  fin_ready_q <= 1'b0;
                  state_q     <= S_ENCODE;
                  for (int j = 0; j < D; j++) cnt_q[j] <= '0;
               end
            end
            S_ENCODE: begin
               for (int j = 0; j < D; j++) cnt_q[j] <= cnt_q[j] + CW'(bound_s[j]);
               id_hv_q <= rule90(id_hv_q);
               ch_q    <= ch_q + CHW'(1);
               if (ch_q == CH_LAST) begin
                  state_q <= S_BUNDLE;
               end
            end
            S_BUNDLE: begin
               query_q <= query_d;
               state_q <= S_SEARCH;
            end
            S_SEARCH: begin
               valence_q    <= am_valence_s;
               arousal_q    <= am_arousal_s;
               dout_valid_q <= 1'b1;
               state_q      <= S_DONE;
            end
            S_DONE: begin
               if (dout_valid_q) begin
                  if (dout_ready) begin
                     dout_valid_q <= 1'b0;
                  end
               end else begin
                  fin_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q      <= S_IDLE;
               fin_ready_q  <= 1'b1;
               dout_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign fin_ready  = fin_ready_q;
   assign dout_valid = dout_valid_q;
   assign valence    = valence_q;
   assign arousal    = arousal_q;
endmodule

// File: tb/tb_hdc_sensor_fusion.sv
// Bench for hdc_sensor_fusion (N=4, W=2, D=32): vector table, scoreboard queue, timing corner sequences.
module tb_hdc_sensor_fusion;
   localparam logic [31:0] T_ID   = 32'h0000_0001;
   localparam logic [31:0] T_LVL  = 32'hA5C3_0F96;
   localparam logic [31:0] T_VHI  = 32'hF0F0_1234;
   localparam logic [31:0] T_VLO  = 32'h0F0F_EDCB;
   localparam logic [31:0] T_AHI  = 32'h3C3C_A5A5;
   localparam logic [31:0] T_ALO  = 32'hC3C3_5A5A;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] features = 8'h00;
   logic       fin_valid = 1'b0;
   logic       dout_ready = 1'b1;
   logic       fin_ready, valence, arousal, dout_valid;
   logic       fin_ready2, valence2, arousal2, dout_valid2;

   int         n_checks = 0;
   int         n_pass = 0;
   int         n_out = 0;
   logic [1:0] sb[$];

   always #5 clk = ~clk;

   hdc_sensor_fusion #(
      .TOTAL_NUM_CHANNEL(4), .CHANNEL_WIDTH(2), .HV_DIM(32),
      .ID_SEED(T_ID), .LEVEL_SEED(T_LVL),
      .V_HI(T_VHI), .V_LO(T_VLO), .A_HI(T_AHI), .A_LO(T_ALO)
   ) dut (
      .clk(clk), .rst(rst), .features_top(features), .fin_valid(fin_valid),
      .fin_ready(fin_ready), .valence(valence), .arousal(arousal),
      .dout_valid(dout_valid), .dout_ready(dout_ready)
   );

   hdc_sensor_fusion #(
      .TOTAL_NUM_CHANNEL(4), .CHANNEL_WIDTH(2), .HV_DIM(32),
      .ID_SEED(T_ID), .LEVEL_SEED(T_LVL),
      .V_HI(T_VHI), .V_LO(T_VHI), .A_HI(T_AHI), .A_LO(T_AHI)
   ) dut_eq (
      .clk(clk), .rst(rst), .features_top(features), .fin_valid(fin_valid),
      .fin_ready(fin_ready2), .valence(valence2), .arousal(arousal2),
      .dout_valid(dout_valid2), .dout_ready(dout_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [31:0] r90(input logic [31:0] c);
      logic [31:0] n;
      for (int j = 0; j < 32; j++) n[j] = c[(j + 31) % 32] ^ c[(j + 1) % 32];
      return n;
   endfunction

   // Reference classifier: returns {valence, arousal}.
   function automatic logic [1:0] model(input logic [7:0] f);
      logic [31:0] idv, lv, q;
      int cnt [32];
      int qv, dvh, dvl, dah, dal;
      idv = T_ID;
      for (int j = 0; j < 32; j++) cnt[j] = 0;
      for (int ch = 0; ch < 4; ch++) begin
         qv = int'(f[ch*2 +: 2]);
         lv = T_LVL;
         for (int j = 0; j < 32; j++) if (j < qv * 8) lv[j] = ~lv[j];
         for (int j = 0; j < 32; j++) cnt[j] += int'(idv[j] ^ lv[j]);
         idv = r90(idv);
      end
      dvh = 0; dvl = 0; dah = 0; dal = 0;
      for (int j = 0; j < 32; j++) begin
`ifdef HDC_MAJ_TIE_ONE_EN
         q[j] = (2 * cnt[j] >= 4);
`else
         q[j] = (2 * cnt[j] > 4);
`endif
         dvh += int'(q[j] ^ T_VHI[j]);
         dvl += int'(q[j] ^ T_VLO[j]);
         dah += int'(q[j] ^ T_AHI[j]);
         dal += int'(q[j] ^ T_ALO[j]);
      end
      return {(dvh < dvl), (dah < dal)};
   endfunction

   // Scoreboard: compare at the negedge ahead of each output handshake.
   always @(negedge clk) begin
      if (rst && dout_valid && dout_ready) begin
         n_out++;
         if (sb.size() == 0) begin
            chk("unexpected_output", 32'(1), 32'(0));
         end else begin
            logic [1:0] e;
            e = sb.pop_front();
            chk("valence", 32'(valence), 32'(e[1]));
            chk("arousal", 32'(arousal), 32'(e[0]));
            chk("eq_proto_labels", {30'd0, valence2, arousal2}, 32'(0));
         end
      end
   end

   task automatic send(input logic [7:0] f, input logic [1:0] e);
      int k;
      @(posedge clk); #1;
      fin_valid = 1'b1;
      features  = f;
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         if (fin_ready) break;
      end
      chk("accept_in_time", 32'(k < 100), 32'(1));
      if (k < 100) sb.push_back(e);
      @(posedge clk); #1;
      fin_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         if (sb.size() == 0 && fin_ready) break;
      end
      chk("drain_in_time", 32'(k < 300), 32'(1));
   endtask

   typedef struct {
      logic [7:0] feat;
      logic [1:0] exp;
   } vec_t;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [7];
      logic [7:0] fv;
      logic [1:0] ev;
      int k, out0;
      logic seen;
      logic drv_done;

      tbl[0].feat = 8'h00; tbl[1].feat = 8'hFF; tbl[2].feat = 8'h1B; tbl[3].feat = 8'hE4;
      tbl[4].feat = 8'h55; tbl[5].feat = 8'hAA; tbl[6].feat = 8'h39;
      for (int i = 0; i < 7; i++) tbl[i].exp = model(tbl[i].feat);

      // Reset state
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_fin_ready", 32'(fin_ready), 32'(1));
      chk("rst_dout_valid", 32'(dout_valid), 32'(0));
      chk("rst_valence", 32'(valence), 32'(0));
      chk("rst_arousal", 32'(arousal), 32'(0));
      rst = 1'b1;

      // Latency: all-zero features, dout_valid exactly N+2 = 6 edges after acceptance
      dout_ready = 1'b1;
      send(8'h00, model(8'h00));
      chk("busy_after_accept", 32'(fin_ready), 32'(0));
      for (k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (dout_valid) break;
      end
      chk("latency", 32'(k), 32'(6));
      drain();

      // Vector table
      for (int i = 0; i < 7; i++) begin
         send(tbl[i].feat, tbl[i].exp);
         drain();
      end

      // Backpressure
      dout_ready = 1'b0;
      fv = 8'hC6;
      ev = model(fv);
      send(fv, ev);
      for (k = 0; k < 50; k++) begin
         @(negedge clk);
         if (dout_valid) break;
      end
      chk("bp_valid_rise", 32'(k < 50), 32'(1));
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!dout_valid || fin_ready || valence !== ev[1] || arousal !== ev[0]) seen = 1'b1;
      end
      chk("bp_stable", 32'(seen), 32'(0));
      chk("bp_valence", 32'(valence), 32'(ev[1]));
      chk("bp_arousal", 32'(arousal), 32'(ev[0]));
      @(posedge clk); #1;
      dout_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid_drop", 32'(dout_valid), 32'(0));
      chk("bp_ready_still_low", 32'(fin_ready), 32'(0));
      @(posedge clk); #1;
      chk("bp_ready_back", 32'(fin_ready), 32'(1));

      // Random traffic with gaps on both sides
      out0 = n_out;
      drv_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               logic [7:0] rf;
               repeat ($urandom_range(0, 15)) @(posedge clk);
               rf = 8'($urandom);
               send(rf, model(rf));
            end
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               repeat ($urandom_range(0, 15)) @(posedge clk);
               #1;
               dout_ready = ~dout_ready;
            end
            dout_ready = 1'b1;
         end
      join
      drain();
      chk("random_count", 32'(n_out - out0), 32'(20));

      // Reset during ENCODE aborts the entry
      dout_ready = 1'b1;
      send(8'h6C, model(8'h6C));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_fin_ready", 32'(fin_ready), 32'(1));
      chk("abort_dout_valid", 32'(dout_valid), 32'(0));
      rst = 1'b1;
      sb.delete();
      out0 = n_out;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (dout_valid) seen = 1'b1;
      end
      chk("abort_no_output", 32'(seen), 32'(0));
      send(8'h93, model(8'h93));
      drain();
      chk("after_abort_count", 32'(n_out - out0), 32'(1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
